// File: rtl/lsu_handshake.sv
// lsu_handshake: load/store unit with a request/grant/response memory handshake.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them.

typedef enum logic [4:0] {
  INSTR_NOP = 5'd0,
  INSTR_ADD = 5'd1,
  INSTR_SUB = 5'd2,
  INSTR_BEQ = 5'd3,
  INSTR_JAL = 5'd4,
  INSTR_LB  = 5'd8,
  INSTR_LH  = 5'd9,
  INSTR_LW  = 5'd10,
  INSTR_LBU = 5'd11,
  INSTR_LHU = 5'd12,
  INSTR_SB  = 5'd16,
  INSTR_SH  = 5'd17,
  INSTR_SW  = 5'd18
} rv32i_instr_e;

module lsu_handshake #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              ex_lsu_valid,
  input  rv32i_instr_e      ex_lsu_instr_type,
  input  logic [ADDR_W-1:0] ex_lsu_addr,
  input  logic [31:0]       ex_lsu_store_data,
  input  logic [4:0]        ex_lsu_rd_addr,
  output logic              lsu_stall,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              wb_load_valid,
  output logic [4:0]        wb_load_rd_addr,
  output logic [31:0]       wb_load_data,
  output logic              lsu_misalign,
  output logic              lsu_bus_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_r;
  state_e            state_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              timeout_s;
  logic              is_load_s;
  logic              is_store_s;
  logic [1:0]        offset_s;
  logic [3:0]        be_s;
  logic [31:0]       wdata_s;
  logic              trap_s;
  logic              req_ok_s;
  logic              accept_s;
  rv32i_instr_e      instr_r;
  logic [1:0]        offset_r;
  logic [4:0]        rd_r;
  logic [7:0]        ld_byte_s;
  logic [15:0]       ld_half_s;
  logic [31:0]       ld_data_s;

  // Request decode: access class, lane offset, byte enables, replicated store data
  always_comb begin
    is_load_s  = 1'b0;
    is_store_s = 1'b0;
    offset_s   = 2'b00;
    be_s       = 4'b0000;
    wdata_s    = 32'h0000_0000;
    case (ex_lsu_instr_type)
      INSTR_LB, INSTR_LBU: begin
        is_load_s = 1'b1;
        offset_s  = ex_lsu_addr[1:0];
        be_s      = 4'b0001 << ex_lsu_addr[1:0];
      end
      INSTR_LH, INSTR_LHU: begin
        is_load_s = 1'b1;
        offset_s  = {ex_lsu_addr[1], 1'b0};
        be_s      = ex_lsu_addr[1] ? 4'b1100 : 4'b0011;
      end
      INSTR_LW: begin
        is_load_s = 1'b1;
        be_s      = 4'b1111;
      end
      INSTR_SB: begin
        is_store_s = 1'b1;
        offset_s   = ex_lsu_addr[1:0];
        be_s       = 4'b0001 << ex_lsu_addr[1:0];
        wdata_s    = {4{ex_lsu_store_data[7:0]}};
      end
      INSTR_SH: begin
        is_store_s = 1'b1;
        offset_s   = {ex_lsu_addr[1], 1'b0};
        be_s       = ex_lsu_addr[1] ? 4'b1100 : 4'b0011;
        wdata_s    = {2{ex_lsu_store_data[15:0]}};
      end
      INSTR_SW: begin
        is_store_s = 1'b1;
        be_s       = 4'b1111;
        wdata_s    = ex_lsu_store_data;
      end
      default: begin
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
      end
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_s = (((ex_lsu_instr_type == INSTR_LH) || (ex_lsu_instr_type == INSTR_LHU) ||
                    (ex_lsu_instr_type == INSTR_SH)) && ex_lsu_addr[0]) ||
                  (((ex_lsu_instr_type == INSTR_LW) || (ex_lsu_instr_type == INSTR_SW)) &&
                    (ex_lsu_addr[1:0] != 2'b00));
`else
  assign trap_s = 1'b0;
`endif

  assign req_ok_s = (state_r == S_IDLE) && ex_lsu_valid && (is_load_s || is_store_s) && !stall;
  assign accept_s = req_ok_s && !trap_s;

  // The stall is combinational so EX holds the instruction in the accept cycle itself
  assign lsu_stall = !rst && (accept_s || (state_r == S_REQ) ||
                              ((state_r == S_WAIT) && !mem_rvalid));

  // Next-state logic; the phase counter bounds both REQ and WAIT
  always_comb begin
    state_nxt_s = state_r;
    timeout_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (accept_s) state_nxt_s = S_REQ;
        else          state_nxt_s = S_IDLE;
      end
      S_REQ: begin
        if (mem_gnt) begin
          state_nxt_s = S_WAIT;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s = S_IDLE;
          timeout_s   = 1'b1;
        end else begin
          state_nxt_s = S_REQ;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          state_nxt_s = S_IDLE;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s = S_IDLE;
          timeout_s   = 1'b1;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register and per-phase counter (cleared on every state change)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (state_nxt_s != state_r) cnt_r <= {CNT_W{1'b0}};
      else if (state_r != S_IDLE) cnt_r <= cnt_r + CNT_W'(1);
      else cnt_r <= {CNT_W{1'b0}};
    end
  end

  // Request outputs are captured at accept and held until the transaction ends
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_wdata <= 32'h0000_0000;
      instr_r   <= INSTR_NOP;
      offset_r  <= 2'b00;
      rd_r      <= 5'd0;
    end else begin
      mem_req <= (state_nxt_s == S_REQ);
      if (accept_s) begin
        mem_addr  <= {ex_lsu_addr[ADDR_W-1:2], 2'b00};
        mem_we    <= is_store_s;
        mem_be    <= be_s;
        mem_wdata <= wdata_s;
        instr_r   <= ex_lsu_instr_type;
        offset_r  <= offset_s;
        rd_r      <= ex_lsu_rd_addr;
      end
    end
  end

  assign ld_byte_s = mem_rdata[{offset_r, 3'b000} +: 8];
  assign ld_half_s = mem_rdata[{offset_r[1], 4'b0000} +: 16];

  // Load lane extraction and extension from the registered offset and type
  always_comb begin
    ld_data_s = mem_rdata;
    case (instr_r)
      INSTR_LB:  ld_data_s = {{24{ld_byte_s[7]}}, ld_byte_s};
      INSTR_LBU: ld_data_s = {24'h00_0000, ld_byte_s};
      INSTR_LH:  ld_data_s = {{16{ld_half_s[15]}}, ld_half_s};
      INSTR_LHU: ld_data_s = {16'h0000, ld_half_s};
      default:   ld_data_s = mem_rdata;
    endcase
  end

  // Writeback and one-cycle status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_load_valid   <= 1'b0;
      wb_load_rd_addr <= 5'd0;
      wb_load_data    <= 32'h0000_0000;
      lsu_misalign    <= 1'b0;
      lsu_bus_err     <= 1'b0;
    end else begin
      wb_load_valid <= (state_r == S_WAIT) && mem_rvalid && !mem_we;
      if ((state_r == S_WAIT) && mem_rvalid && !mem_we) begin
        wb_load_rd_addr <= rd_r;
        wb_load_data    <= ld_data_s;
      end
      lsu_misalign <= req_ok_s && trap_s;
      lsu_bus_err  <= timeout_s;
    end
  end

endmodule

// File: tb/tb_lsu_handshake.sv
// tb_lsu_handshake: directed self-checking bench for lsu_handshake.
// Covers stores, sub-word loads, timeout, misalignment and reset mid-access.

module tb_lsu_handshake;

  logic         clk;
  logic         rst;
  logic         stall;
  logic         ex_lsu_valid;
  rv32i_instr_e ex_lsu_instr_type;
  logic [31:0]  ex_lsu_addr;
  logic [31:0]  ex_lsu_store_data;
  logic [4:0]   ex_lsu_rd_addr;
  logic         lsu_stall;
  logic         mem_req;
  logic         mem_gnt;
  logic [31:0]  mem_addr;
  logic         mem_we;
  logic [3:0]   mem_be;
  logic [31:0]  mem_wdata;
  logic         mem_rvalid;
  logic [31:0]  mem_rdata;
  logic         wb_load_valid;
  logic [4:0]   wb_load_rd_addr;
  logic [31:0]  wb_load_data;
  logic         lsu_misalign;
  logic         lsu_bus_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;

  lsu_handshake #(.ADDR_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .ex_lsu_valid(ex_lsu_valid), .ex_lsu_instr_type(ex_lsu_instr_type),
    .ex_lsu_addr(ex_lsu_addr), .ex_lsu_store_data(ex_lsu_store_data),
    .ex_lsu_rd_addr(ex_lsu_rd_addr), .lsu_stall(lsu_stall),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .wb_load_valid(wb_load_valid),
    .wb_load_rd_addr(wb_load_rd_addr), .wb_load_data(wb_load_data),
    .lsu_misalign(lsu_misalign), .lsu_bus_err(lsu_bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // One full access: accept, gw grant waits, rw response waits, then response.
  // Returns in the cycle after the response edge, with EX inputs released.
  task automatic run_op(input rv32i_instr_e t, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rdv, input logic [4:0] rd,
                        input int gw, input int rw, input logic hold_stall);
    ex_lsu_valid = 1'b1; ex_lsu_instr_type = t; ex_lsu_addr = a;
    ex_lsu_store_data = d; ex_lsu_rd_addr = rd;
    #1 check("stall_on_accept", {31'd0, lsu_stall}, 32'd1);
    cyc();
    stall = hold_stall;
    for (int i = 0; i < gw; i++) begin
      #1 check("req_held", {31'd0, mem_req}, 32'd1);
      check("stall_in_req", {31'd0, lsu_stall}, 32'd1);
      cyc();
    end
    mem_gnt = 1'b1;
    #1 check("req_at_gnt", {31'd0, mem_req}, 32'd1);
    cap_addr = mem_addr; cap_wdata = mem_wdata; cap_be = mem_be; cap_we = mem_we;
    cyc();
    mem_gnt = 1'b0;
    #1 check("req_low_after_gnt", {31'd0, mem_req}, 32'd0);
    for (int i = 0; i < rw; i++) begin
      check("stall_in_wait", {31'd0, lsu_stall}, 32'd1);
      cyc();
      #1;
    end
    mem_rvalid = 1'b1; mem_rdata = rdv;
    #1 check("stall_low_at_rsp", {31'd0, lsu_stall}, 32'd0);
    cyc();
    mem_rvalid = 1'b0; ex_lsu_valid = 1'b0; ex_lsu_instr_type = INSTR_NOP; stall = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; ex_lsu_valid = 1'b1; ex_lsu_instr_type = INSTR_LW;
    ex_lsu_addr = 32'h0; ex_lsu_store_data = 32'h0; ex_lsu_rd_addr = 5'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

    // Reset state, with a load presented to prove the stall is forced low
    cyc();
    #1;
    check("rst_stall", {31'd0, lsu_stall}, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_be", {28'd0, mem_be}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_wb_valid", {31'd0, wb_load_valid}, 32'd0);
    check("rst_wb_data", wb_load_data, 32'h0);
    check("rst_misalign", {31'd0, lsu_misalign}, 32'd0);
    check("rst_bus_err", {31'd0, lsu_bus_err}, 32'd0);
    ex_lsu_valid = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();

    // Non-memory instruction passes through
    ex_lsu_valid = 1'b1; ex_lsu_instr_type = INSTR_ADD;
    #1 check("alu_no_stall", {31'd0, lsu_stall}, 32'd0);
    cyc();
    ex_lsu_valid = 1'b0;
    #1 check("alu_no_req", {31'd0, mem_req}, 32'd0);

    // Pipeline stall blocks acceptance
    ex_lsu_valid = 1'b1; ex_lsu_instr_type = INSTR_LW; ex_lsu_addr = 32'h0000_0100; stall = 1'b1;
    #1 check("stall_blocks", {31'd0, lsu_stall}, 32'd0);
    cyc();
    #1 check("stall_no_req", {31'd0, mem_req}, 32'd0);
    ex_lsu_valid = 1'b0; stall = 1'b0;
    cyc();

    // SB 0x1003
    run_op(INSTR_SB, 32'h0000_1003, 32'h0000_00AB, 32'h0, 5'd0, 0, 0, 1'b0);
    check("sb_addr", cap_addr, 32'h0000_1000);
    check("sb_be", {28'd0, cap_be}, 32'h0000_0008);
    check("sb_wdata", cap_wdata, 32'hABAB_ABAB);
    check("sb_we", {31'd0, cap_we}, 32'd1);
    check("sb_no_wb", {31'd0, wb_load_valid}, 32'd0);
    cyc();

    // LB 0x2001 with grant and response waits, pipeline stall held high
    run_op(INSTR_LB, 32'h0000_2001, 32'h0, 32'h0000_F000, 5'd5, 2, 3, 1'b1);
    check("lb_be", {28'd0, cap_be}, 32'h0000_0002);
    check("lb_we", {31'd0, cap_we}, 32'd0);
    check("lb_wb_valid", {31'd0, wb_load_valid}, 32'd1);
    check("lb_wb_data", wb_load_data, 32'hFFFF_FFF0);
    check("lb_wb_rd", {27'd0, wb_load_rd_addr}, 32'd5);
    cyc();
    #1 check("lb_one_strobe", {31'd0, wb_load_valid}, 32'd0);
    cyc();

    // LHU then LH back-to-back at 0x2002
    run_op(INSTR_LHU, 32'h0000_2002, 32'h0, 32'h8001_0000, 5'd7, 0, 0, 1'b0);
    check("lhu_be", {28'd0, cap_be}, 32'h0000_000C);
    check("lhu_wb_data", wb_load_data, 32'h0000_8001);
    check("lhu_wb_rd", {27'd0, wb_load_rd_addr}, 32'd7);
    run_op(INSTR_LH, 32'h0000_2002, 32'h0, 32'h8001_0000, 5'd8, 0, 1, 1'b0);
    check("lh_wb_valid", {31'd0, wb_load_valid}, 32'd1);
    check("lh_wb_data", wb_load_data, 32'hFFFF_8001);
    cyc();

    // SH 0x4002
    run_op(INSTR_SH, 32'h0000_4002, 32'h1234_ABCD, 32'h0, 5'd0, 1, 0, 1'b0);
    check("sh_be", {28'd0, cap_be}, 32'h0000_000C);
    check("sh_wdata", cap_wdata, 32'hABCD_ABCD);
    check("sh_no_wb", {31'd0, wb_load_valid}, 32'd0);
    cyc();

    // Misaligned LW 0x3002
`ifdef LSU_MISALIGN_TRAP_EN
    ex_lsu_valid = 1'b1; ex_lsu_instr_type = INSTR_LW; ex_lsu_addr = 32'h0000_3002;
    #1 check("mis_no_stall", {31'd0, lsu_stall}, 32'd0);
    cyc();
    ex_lsu_valid = 1'b0;
    #1 check("mis_no_req", {31'd0, mem_req}, 32'd0);
    check("mis_pulse", {31'd0, lsu_misalign}, 32'd1);
    cyc();
    #1 check("mis_pulse_end", {31'd0, lsu_misalign}, 32'd0);
`else
    run_op(INSTR_LW, 32'h0000_3002, 32'h0, 32'hCAFE_F00D, 5'd9, 0, 0, 1'b0);
    check("lw_al_addr", cap_addr, 32'h0000_3000);
    check("lw_al_be", {28'd0, cap_be}, 32'h0000_000F);
    check("lw_al_data", wb_load_data, 32'hCAFE_F00D);
    check("lw_al_no_mis", {31'd0, lsu_misalign}, 32'd0);
`endif
    cyc();

    // LW granted, response never arrives: timeout after 16 WAIT cycles
    ex_lsu_valid = 1'b1; ex_lsu_instr_type = INSTR_LW; ex_lsu_addr = 32'h0000_5000;
    cyc();
    mem_gnt = 1'b1;
    cyc();
    mem_gnt = 1'b0; ex_lsu_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1 check("to_stall", {31'd0, lsu_stall}, 32'd1);
      check("to_no_err_yet", {31'd0, lsu_bus_err}, 32'd0);
      cyc();
    end
    #1 check("to_err", {31'd0, lsu_bus_err}, 32'd1);
    check("to_no_wb", {31'd0, wb_load_valid}, 32'd0);
    check("to_stall_low", {31'd0, lsu_stall}, 32'd0);
    check("to_req_low", {31'd0, mem_req}, 32'd0);
    cyc();
    #1 check("to_err_end", {31'd0, lsu_bus_err}, 32'd0);

    // Reset while in WAIT, then a stray response
    ex_lsu_valid = 1'b1; ex_lsu_instr_type = INSTR_LW; ex_lsu_addr = 32'h0000_6000;
    cyc();
    mem_gnt = 1'b1;
    cyc();
    mem_gnt = 1'b0; ex_lsu_valid = 1'b0;
    #1 check("pre_rst_addr", mem_addr, 32'h0000_6000);
    rst = 1'b1;
    #1 check("mid_rst_addr", mem_addr, 32'h0);
    check("mid_rst_be", {28'd0, mem_be}, 32'd0);
    check("mid_rst_req", {31'd0, mem_req}, 32'd0);
    check("mid_rst_stall", {31'd0, lsu_stall}, 32'd0);
    check("mid_rst_wb_data", wb_load_data, 32'h0);
    cyc();
    rst = 1'b0;
    cyc();
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    #1 check("stray_no_stall", {31'd0, lsu_stall}, 32'd0);
    cyc();
    mem_rvalid = 1'b0;
    #1 check("stray_no_wb", {31'd0, wb_load_valid}, 32'd0);
    check("stray_no_req", {31'd0, mem_req}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_handshake.md
# lsu_handshake

Second-generation load/store unit for the mini-rv core. It sits between the execute stage and a data memory with a request/grant/response handshake, so memory latency is no longer fixed at one cycle. It supports sub-word accesses with byte enables and sign/zero extension, and it stalls the pipeline while an access is outstanding. It reports misaligned accesses (configurable) and bus timeouts.

## Interface
- `ADDR_W`, 32: byte-address width.
- `TIMEOUT`, 16: cycles allowed per handshake phase before a bus error; must be ≥ 2.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `stall` in 1: pipeline stall; blocks acceptance of new requests.
- `ex_lsu_valid` in 1: EX presents an instruction.
- `ex_lsu_instr_type` in `rv32i_instr_e`: only LB/LH/LW/LBU/LHU/SB/SH/SW act.
- `ex_lsu_addr` in `ADDR_W`: effective byte address (rs1+imm).
- `ex_lsu_store_data` in 32: rs2 data.
- `ex_lsu_rd_addr` in 5: load destination.
- `lsu_stall` out 1: hold the pipeline.
- `mem_req` out 1: request valid.
- `mem_gnt` in 1: request accepted.
- `mem_addr` out `ADDR_W`: word-aligned address `{addr[ADDR_W-1:2],2'b00}`.
- `mem_we` out 1: 1 for store.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_rvalid` in 1: response valid.
- `mem_rdata` in 32: load word.
- `wb_load_valid` out 1: one-cycle load result strobe.
- `wb_load_rd_addr` out 5: destination register.
- `wb_load_data` out 32: extended load data.
- `lsu_misalign` out 1: one-cycle misalignment pulse.
- `lsu_bus_err` out 1: one-cycle timeout pulse.

## Operation
- FSM states: IDLE, REQ, WAIT.
- Accept = IDLE && `ex_lsu_valid` && mem op && !`stall` && !misaligned-trap.
- IDLE→REQ on accept.
  - In the same edge, register `mem_addr`, `mem_we`, `mem_be`, `mem_wdata`, rd, type and offset.
- REQ: `mem_req`=1; all request outputs are held stable until `mem_gnt`. REQ→WAIT on `mem_gnt`.
- WAIT: `mem_req`=0. `mem_rvalid` → IDLE.
  - Load: register the extended data, set `wb_load_valid`=1.
  - Store: response is acknowledgement only; no writeback.
- `mem_rvalid` outside WAIT is ignored. Memory must not assert `mem_rvalid` in the grant cycle.
- Byte enables and write data:
  - SB: `mem_be`=1<<addr[1:0]; `mem_wdata`={4{d[7:0]}}.
  - SH: `mem_be`=addr[1]?4'b1100:4'b0011; `mem_wdata`={2{d[15:0]}}.
  - SW: `mem_be`=4'b1111; `mem_wdata`=d.
- Load extraction uses the registered offset.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Timeout:
  - An internal counter clears on every state entry and increments each cycle spent in REQ or WAIT.
  - At count `TIMEOUT`-1 with no `mem_gnt`/`mem_rvalid` response: `lsu_bus_err` pulses, FSM returns to IDLE, no writeback, `mem_req` drops.
- `lsu_stall` = accept || state==REQ || (state==WAIT && !`mem_rvalid`). It is forced to 0 while `rst` is high.
- Non-memory instructions pass through: no stall, no outputs.

## Timing
- Reset: state IDLE; counter 0; every registered output is 0. This includes `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`, `wb_load_*`, `lsu_misalign` and `lsu_bus_err`.
- Reset mid-access abandons the access immediately; `mem_req` drops asynchronously.
- Accept at edge N: `mem_req` is high from N.
- Grant sampled at edge G: `mem_req` is low after G.
- `mem_rvalid` sampled at edge R: `wb_load_valid` is high for the cycle after R, and `lsu_stall` is low in the cycle before R.
- Minimum load latency with zero-wait memory: accept→wb 3 edges.
- Back-to-back: the next instruction is accepted no earlier than the edge after R.
- `stall` high in REQ or WAIT does not pause the handshake.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
  - A misaligned request is never issued; it causes `lsu_misalign`=1 for one cycle after the edge and no stall.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - `lsu_misalign` is tied 0.
  - Halfword accesses ignore addr[0]; word accesses ignore addr[1:0]. The access proceeds aligned.

## Test plan
- SB addr 0x1003, data 0x000000AB, gnt next cycle → `mem_addr` 0x1000, `mem_be` 4'b1000, `mem_wdata` 0xABABABAB, `mem_we`=1; no `wb_load_valid`.
- LB addr 0x2001, rdata 0x0000F000, gnt after 2 waits, rvalid after 3 more → `lsu_stall` high throughout; `wb_load_data` 0xFFFFFFF0, rd as given, exactly one strobe.
- LHU addr 0x2002, rdata 0x8001_0000 → `wb_load_data` 0x00008001. LH at the same address → 0xFFFF8001.
- LW, gnt given, no rvalid for 16 cycles → `lsu_bus_err` pulse, no writeback, FSM idle, `lsu_stall` low.
- LW addr 0x3002 with macro defined → no `mem_req`, one `lsu_misalign` pulse. Without the macro → `mem_addr` 0x3000, `mem_be` 4'b1111.
- Assert `rst` while in WAIT → all outputs 0 immediately. A later `mem_rvalid` produces no writeback.
